// File: rtl/to_upper_if.sv
// Byte-stream bus for to_upper: legacy bit-level byte ports plus valid/flag/counter.
interface to_upper_if #(
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             A0, A1, A2, A3, A4, A5, A6, A7;
  logic             clr_count;
  logic             out_valid;
  logic             B0, B1, B2, B3, B4, B5, B6, B7;
  logic             converted;
  logic [CNT_W-1:0] conv_count;

  // Byte source / result consumer side
  modport master (
    output in_valid, A0, A1, A2, A3, A4, A5, A6, A7, clr_count,
    input  out_valid, B0, B1, B2, B3, B4, B5, B6, B7, converted, conv_count
  );

  // Converter side
  modport slave (
    input  in_valid, A0, A1, A2, A3, A4, A5, A6, A7, clr_count,
    output out_valid, B0, B1, B2, B3, B4, B5, B6, B7, converted, conv_count
  );
endinterface

// File: rtl/to_upper.sv
// Registered ASCII lowercase-to-uppercase converter with one-cycle latency,
// per-byte converted flag and a saturating conversion counter.
// Optional macro TO_UPPER_LATIN1_EN: also converts ISO-8859-1 lowercase
// letters 0xE0..0xFE (except 0xF7).
module to_upper #(
  parameter int unsigned CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  to_upper_if.slave   bus
);

  localparam int unsigned BYTE_W = 8;

  logic [BYTE_W-1:0] a_c;
  logic [BYTE_W-1:0] f_c;
  logic              hit_c;

  logic [BYTE_W-1:0] byte_q, byte_d;
  logic              valid_q, valid_d;
  logic              conv_q, conv_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Reassemble the legacy bit ports into a byte
  assign a_c = {bus.A7, bus.A6, bus.A5, bus.A4, bus.A3, bus.A2, bus.A1, bus.A0};

  // Conversion function: clear bit 5 for lowercase letters
  always_comb begin
    hit_c = (a_c >= 8'h61) && (a_c <= 8'h7A);
`ifdef TO_UPPER_LATIN1_EN
    hit_c = hit_c || ((a_c >= 8'hE0) && (a_c <= 8'hFE) && (a_c != 8'hF7));
`else
    hit_c = hit_c && !a_c[7];
`endif
    f_c = hit_c ? (a_c & 8'hDF) : a_c;
  end

  // Next-state: capture on valid, B holds when idle, clear beats increment
  always_comb begin
    byte_d  = byte_q;
    valid_d = bus.in_valid;
    conv_d  = 1'b0;
    cnt_d   = cnt_q;
    if (bus.in_valid) begin
      byte_d = f_c;
      conv_d = hit_c;
    end
    if (bus.clr_count) begin
      cnt_d = '0;
    end else if (bus.in_valid && hit_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_q  <= '0;
      valid_q <= 1'b0;
      conv_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      byte_q  <= byte_d;
      valid_q <= valid_d;
      conv_q  <= conv_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.converted  = conv_q;
  assign bus.conv_count = cnt_q;
  assign bus.B0 = byte_q[0];
  assign bus.B1 = byte_q[1];
  assign bus.B2 = byte_q[2];
  assign bus.B3 = byte_q[3];
  assign bus.B4 = byte_q[4];
  assign bus.B5 = byte_q[5];
  assign bus.B6 = byte_q[6];
  assign bus.B7 = byte_q[7];

endmodule

// File: tb/tb_to_upper.sv
// Self-checking bench for to_upper: default-width and CNT_W=2 instances driven
// in lockstep and compared against a behavioural reference model.
module tb_to_upper;

  logic clk;
  logic rst_n;

  int checks;
  int failures;

  to_upper_if #(.CNT_W(16)) bus_a ();
  to_upper_if #(.CNT_W(2))  bus_b ();

  to_upper #(.CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  to_upper #(.CNT_W(2))  dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic       exp_valid;
  logic [7:0] exp_b;
  logic       exp_conv;
  int         exp_cnt_a;
  int         exp_cnt_b;

  function automatic int ref_f(input int a);
    if (a >= 97 && a <= 122) return a - 32;
`ifdef TO_UPPER_LATIN1_EN
    if (a >= 224 && a <= 254 && a != 247) return a - 32;
`endif
    return a;
  endfunction

  task automatic model_reset();
    exp_valid = 1'b0;
    exp_b     = 8'h00;
    exp_conv  = 1'b0;
    exp_cnt_a = 0;
    exp_cnt_b = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] a, input logic c);
    int fa;
    fa = ref_f(int'(a));
    exp_valid = v;
    exp_conv  = v && (fa != int'(a));
    if (v) exp_b = 8'(fa);
    if (c) begin
      exp_cnt_a = 0;
      exp_cnt_b = 0;
    end else if (v && fa != int'(a)) begin
      if (exp_cnt_a < 65535) exp_cnt_a++;
      if (exp_cnt_b < 3) exp_cnt_b++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    logic [7:0] ba, bb;
    ba = {bus_a.B7, bus_a.B6, bus_a.B5, bus_a.B4, bus_a.B3, bus_a.B2, bus_a.B1, bus_a.B0};
    bb = {bus_b.B7, bus_b.B6, bus_b.B5, bus_b.B4, bus_b.B3, bus_b.B2, bus_b.B1, bus_b.B0};
    chk({tag, ".valid"},  32'(bus_a.out_valid),  32'(exp_valid));
    chk({tag, ".b"},      32'(ba),               32'(exp_b));
    chk({tag, ".conv"},   32'(bus_a.converted),  32'(exp_conv));
    chk({tag, ".cnt"},    32'(bus_a.conv_count), 32'(exp_cnt_a));
    chk({tag, ".b2"},     32'(bb),               32'(exp_b));
    chk({tag, ".cnt2"},   32'(bus_b.conv_count), 32'(exp_cnt_b));
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic c);
    bus_a.in_valid = v;  bus_b.in_valid = v;
    bus_a.clr_count = c; bus_b.clr_count = c;
    {bus_a.A7, bus_a.A6, bus_a.A5, bus_a.A4, bus_a.A3, bus_a.A2, bus_a.A1, bus_a.A0} = a;
    {bus_b.A7, bus_b.A6, bus_b.A5, bus_b.A4, bus_b.A3, bus_b.A2, bus_b.A1, bus_b.A0} = a;
  endtask

  // Check the previous cycle's result, then present the next input
  task automatic step(input string tag, input logic v, input logic [7:0] a, input logic c);
    @(negedge clk);
    chk_all(tag);
    drive(v, a, c);
    model_step(v, a, c);
  endtask

  logic [7:0] pass_v [10] = '{8'h28, 8'h48, 8'h41, 8'h47, 8'h30, 8'h3A, 8'h14, 8'h7F, 8'h60, 8'h7B};
  logic [7:0] conv_v [3]  = '{8'h61, 8'h7A, 8'h6D};
  logic [7:0] strm_v [19] = '{8'h28, 8'h48, 8'hB7, 8'h83, 8'h7C, 8'h14, 8'hEB, 8'h61, 8'h41, 8'h7A,
                              8'h47, 8'h6D, 8'h92, 8'h30, 8'hCF, 8'h3A, 8'h7B, 8'h94, 8'h7F};

  initial begin
    logic [7:0] rb;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset
    step("idle", 1'b0, 8'h00, 1'b0);
    step("idle", 1'b0, 8'h00, 1'b0);

    // Passthrough bytes
    foreach (pass_v[i]) step("pass", 1'b1, pass_v[i], 1'b0);
    // Conversions
    foreach (conv_v[i]) step("conv", 1'b1, conv_v[i], 1'b0);
    step("conv", 1'b0, 8'h00, 1'b0);

    // Streaming count from a cleared counter
    step("clr", 1'b0, 8'h00, 1'b1);
    foreach (strm_v[i]) step("strm", 1'b1, strm_v[i], 1'b0);
    step("strm", 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk_all("strm_end");
    drive(1'b0, 8'h00, 1'b0);
    model_step(1'b0, 8'h00, 1'b0);
`ifdef TO_UPPER_LATIN1_EN
    chk("strm_final_cnt", 32'(bus_a.conv_count), 32'd4);
`else
    chk("strm_final_cnt", 32'(bus_a.conv_count), 32'd3);
`endif

    // Saturation on the 2-bit instance, then clear beating a conversion
    step("sat", 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) step("sat", 1'b1, 8'h71, 1'b0);
    step("sat", 1'b1, 8'h61, 1'b1);
    step("satclr", 1'b0, 8'h00, 1'b0);
    chk("clr_wins", 32'(bus_b.conv_count), 32'd0);

    // Gaps: valid every other cycle, B holds while idle
    for (int i = 0; i < 6; i++) step("gap", (i % 2) == 0, 8'h62, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      rb = 8'($urandom_range(0, 255));
      step("rand", 1'($urandom_range(0, 3) != 0), rb, 1'($urandom_range(0, 19) == 0));
    end

    // Asynchronous reset mid-cycle while out_valid is high
    step("prerst", 1'b1, 8'h63, 1'b0);
    @(posedge clk);
    #2;
    chk("prerst.valid", 32'(bus_a.out_valid), 32'd1);
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    #1;
    model_reset();
    chk_all("async_rst");
    @(negedge clk);
    chk_all("in_rst");
    rst_n = 1'b1;
    step("postrst", 1'b0, 8'h00, 1'b0);
    step("postrst", 1'b1, 8'h7A, 1'b0);
    step("postrst", 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk_all("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/to_upper.md
Name: to_upper

Overview:
- Registered ASCII case converter for a byte stream. Each valid input byte is emitted one clock later.
- Lowercase letters are rewritten to uppercase; every other byte passes through unchanged.
- Keeps the legacy bit-level byte ports (A0..A7 in, B0..B7 out).
- Adds a valid handshake, a per-byte "converted" flag and a saturating conversion counter, for use ahead of text-matching logic.

Parameters:
- CNT_W, 16, width of the conv_count saturating counter; legal range is 1 to 32.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies A0..A7 in the current cycle.
- A0..A7  input  1 each  input byte; A0 is the LSB, A7 the MSB.
- clr_count  input  1  synchronous clear of conv_count.
- out_valid  output  1  B0..B7 and converted are valid this cycle.
- B0..B7  output  1 each  output byte; B0 is the LSB, B7 the MSB.
- converted  output  1  the byte now on B was changed by conversion.
- conv_count  output  CNT_W  number of bytes converted since reset or clear; saturates at maximum.

Behaviour:
- Reset (rst_n low, asynchronous): B=0x00, out_valid=0, converted=0, conv_count=0. All outputs hold these values while rst_n is low.
- Release of reset is synchronous to clk; the first capture happens on the first rising edge with rst_n high.
- Conversion function f(A), 8-bit:
  - If 0x61 <= A <= 0x7A, then f = A with bit 5 cleared (equivalently A - 0x20).
  - Otherwise f = A.
- Boundary bytes that are not converted: 0x60 '`', 0x7B '{', 0x7F DEL, and 0x41..0x5A (already uppercase).
- Bytes with A7=1 are not converted (but see Optional Feature).
- Latency is exactly 1 cycle. On a rising edge with in_valid=1:
  - B <= f(A)
  - out_valid <= 1
  - converted <= (f(A) != A)
- On a rising edge with in_valid=0:
  - out_valid <= 0
  - converted <= 0
  - B holds its last value.
- No backpressure: the block accepts one byte every cycle, back-to-back.
- conv_count, on each rising edge:
  - If clr_count=1, conv_count <= 0. Clear wins over a simultaneous conversion, so that conversion is not counted.
  - Else, if in_valid=1 and the byte converts, conv_count increments by 1.
  - The counter saturates at 2^CNT_W - 1 and never wraps.
- Reset in mid-stream discards any pending output immediately. A byte presented during reset is lost.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: TO_UPPER_LATIN1_EN.
- When defined, f also converts ISO-8859-1 lowercase letters by clearing bit 5:
  - range 0xE0..0xFE, excluding 0xF7 (division sign);
  - 0xFF (y-diaeresis) is not converted.
- These conversions set converted and increment conv_count exactly like ASCII conversions.
- When undefined, every byte with A7=1 passes through unchanged, with converted=0.

Test Plan:
- Reset/idle: assert rst_n=0 mid-cycle with out_valid=1 → outputs are 0 immediately, before any clock edge. After release, with in_valid=0 → out_valid stays 0 and conv_count=0.
- Passthrough: in_valid=1 with bytes 0x28, 0x48, 0x41, 0x47, 0x30, 0x3A, 0x14, 0x7F, 0x60, 0x7B → the same values appear one cycle later with converted=0.
- Conversion: 0x61, 0x7A, 0x6D → 0x41, 0x5A, 0x4D one cycle later with converted=1.
- Streaming count: present back-to-back 0x28, 0x48, 0xB7, 0x83, 0x7C, 0x14, 0xEB, 0x61, 0x41, 0x7A, 0x47, 0x6D, 0x92, 0x30, 0xCF, 0x3A, 0x7B, 0x94, 0x7F. Required results:
  - outputs match f per cycle;
  - 0xEB → 0xEB without the macro, or 0xCB with the macro;
  - final conv_count = 3 without the macro, or 4 with it.
- Counter: with CNT_W=2, send 5 lowercase bytes → count reads 1, 2, 3, 3, 3. Assert clr_count in the same cycle as a lowercase byte → conv_count=0 next cycle.
- Gaps: alternate in_valid 1/0 with byte 0x62 → B=0x42 and out_valid pulses every other cycle; B holds 0x42 while idle.
